// File: rtl/dsp_result_collector.sv
// dsp_result_collector: tracks in-flight DSP operations by pass count and
// captures each finished sum with its tag into a first-word-fall-through FIFO.
module dsp_result_collector #(
  parameter int N        = 33,
  parameter int DEPTH    = 4,
  parameter int TAG_BITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [TAG_BITS-1:0]        tag,
  input  logic [2*N-1:0]             dsp_out,
  output logic [2*N-1:0]             res_data,
  output logic [TAG_BITS-1:0]        res_tag,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t                     r_state, w_next;
  logic [2:0]                 r_cnt;
  logic [TAG_BITS-1:0]        r_tag;
  logic [2*N+TAG_BITS-1:0]    r_mem [DEPTH];
  logic [AW-1:0]              r_wp, r_rp;
  logic [LW-1:0]              r_level;
  logic                       r_err, r_ovf;
  logic                       w_done, w_legal, w_accept, w_bad;
  logic                       w_pop, w_full, w_wr, w_drop;
  logic [2:0]                 w_load;
  assign w_done   = (r_state == RUN) && (r_cnt == 3'd1);
  assign w_legal  = (mode != 2'd3);
  assign w_accept = start && w_legal && ((r_state == IDLE) || w_done);
  assign w_bad    = start && (!w_legal || ((r_state == RUN) && !w_done));
  assign w_load   = (mode == 2'd0) ? 3'd1 : (mode == 2'd1) ? 3'd2 : 3'd4;
  assign w_pop    = res_valid && res_ready;
  assign w_full   = (r_level == LW'(DEPTH));
  // a full FIFO still takes the push when the head leaves in the same edge
  assign w_wr     = w_done && (!w_full || w_pop);
  assign w_drop   = w_done && w_full && !w_pop;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb
    w_next = w_accept ? RUN : (w_done ? IDLE : r_state);
  always_comb
    busy = (r_state == RUN);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_tag <= '0;
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_accept ? w_load : (r_state == RUN) ? r_cnt - 3'd1 : r_cnt;
      r_tag <= w_accept ? tag : r_tag;
      r_err <= r_err | w_bad;
      r_ovf <= r_ovf | w_drop;
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= {dsp_out, r_tag};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      r_wp    <= w_wr  ? r_wp + AW'(1) : r_wp;
      r_rp    <= w_pop ? r_rp + AW'(1) : r_rp;
      r_level <= r_level + LW'(w_wr) - LW'(w_pop);
    end
  // empty FIFO presents zeros so stale entries never leak after reset
  assign res_valid = (r_level != '0);
  assign res_data  = res_valid ? r_mem[r_rp][2*N+TAG_BITS-1:TAG_BITS] : '0;
  assign res_tag   = res_valid ? r_mem[r_rp][TAG_BITS-1:0] : '0;
  assign level     = r_level;
  assign err       = r_err;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_dsp_result_collector.sv
// tb_dsp_result_collector: directed scoreboard bench for dsp_result_collector.
module tb_dsp_result_collector;
  localparam int N  = 33;
  localparam int TB = 4;
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [TB-1:0]   tag = '0;
  logic [2*N-1:0]  dsp_out = '0;
  logic [2*N-1:0]  res_data;
  logic [TB-1:0]   res_tag;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic            busy;
  logic [2:0]      level;
  logic            err;
  logic            overflow;
  logic [2*N+TB-1:0] sb[$];
  int n_chk = 0;
  int n_fail = 0;

  dsp_result_collector #(.N(N), .DEPTH(4), .TAG_BITS(TB)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .tag(tag),
    .dsp_out(dsp_out), .res_data(res_data), .res_tag(res_tag),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
    .level(level), .err(err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] o, input logic [127:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, o, e);
    end
  endtask

  function automatic logic [2*N-1:0] rnd();
    return {2'($urandom()), $urandom(), $urandom()};
  endfunction

  // a pop happens at the coming edge when valid and ready are high at the negedge
  task automatic tick();
    logic [2*N+TB-1:0] e;
    @(negedge clk);
    if (!rst && res_valid && res_ready) begin
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      chk("pop_data", 128'(res_data), 128'(e[2*N+TB-1:TB]));
      chk("pop_tag", 128'(res_tag), 128'(e[TB-1:0]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_valid", 128'(res_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_level", 128'(level), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));
    chk("rst_data", 128'(res_data), 128'(0));
    chk("rst_tag", 128'(res_tag), 128'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic op0(input logic [TB-1:0] t, input logic [2*N-1:0] v, input bit keep);
    start = 1'b1; mode = 2'd0; tag = t; dsp_out = rnd();
    tick();
    start = 1'b0; dsp_out = v;
    if (keep) sb.push_back({v, t});
    tick();
    dsp_out = rnd();
  endtask

  initial begin
    logic [2*N-1:0] v;
    #1;
    do_reset();
    // single pass with first start right after reset release
    res_ready = 1'b1;
    start = 1'b1; mode = 2'd0; tag = 4'd3; dsp_out = rnd();
    tick();
    start = 1'b0; v = 66'h1_2345_6789; dsp_out = v; sb.push_back({v, 4'd3});
    chk("m0_busy", 128'(busy), 128'(1));
    tick();
    dsp_out = rnd();
    chk("m0_valid", 128'(res_valid), 128'(1));
    chk("m0_data", 128'(res_data), 128'(66'h1_2345_6789));
    chk("m0_tag", 128'(res_tag), 128'(3));
    chk("m0_level", 128'(level), 128'(1));
    tick();
    chk("m0_drained", 128'(level), 128'(0));
    // back-to-back: two pass then single pass started in the completion cycle
    start = 1'b1; mode = 2'd1; tag = 4'd1; dsp_out = rnd();
    tick();
    start = 1'b0; dsp_out = rnd();
    tick();
    start = 1'b1; mode = 2'd0; tag = 4'd2; v = rnd(); dsp_out = v; sb.push_back({v, 4'd1});
    tick();
    start = 1'b0; v = rnd(); dsp_out = v; sb.push_back({v, 4'd2});
    chk("b2b_busy", 128'(busy), 128'(1));
    tick();
    dsp_out = rnd();
    chk("b2b_idle", 128'(busy), 128'(0));
    tick();
    tick();
    chk("b2b_level", 128'(level), 128'(0));
    chk("b2b_noerr", 128'(err), 128'(0));
    // four pass with an ignored start in the middle
    start = 1'b1; mode = 2'd2; tag = 4'd5; dsp_out = rnd();
    tick();
    start = 1'b0; dsp_out = rnd();
    chk("m2_busy1", 128'(busy), 128'(1));
    tick();
    start = 1'b1; mode = 2'd0; tag = 4'd9;
    chk("m2_busy2", 128'(busy), 128'(1));
    tick();
    start = 1'b0;
    chk("m2_err", 128'(err), 128'(1));
    chk("m2_busy3", 128'(busy), 128'(1));
    tick();
    v = rnd(); dsp_out = v; sb.push_back({v, 4'd5});
    chk("m2_busy4", 128'(busy), 128'(1));
    chk("m2_nocap", 128'(level), 128'(0));
    tick();
    dsp_out = rnd();
    chk("m2_idle", 128'(busy), 128'(0));
    chk("m2_level", 128'(level), 128'(1));
    tick();
    tick();
    chk("m2_single", 128'(level), 128'(0));
    // overflow: five results into a four-entry FIFO with no consumer
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) op0(TB'(i + 10), rnd(), i < 4);
    chk("ovf_level", 128'(level), 128'(4));
    chk("ovf_flag", 128'(overflow), 128'(1));
    res_ready = 1'b1;
    repeat (4) tick();
    chk("ovf_drained", 128'(level), 128'(0));
    tick();
    chk("ovf_exact4", 128'(res_valid), 128'(0));
    // full FIFO with simultaneous pop and push
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) op0(TB'(i + 1), rnd(), 1'b1);
    chk("full_level", 128'(level), 128'(4));
    start = 1'b1; mode = 2'd0; tag = 4'd7; dsp_out = rnd();
    tick();
    start = 1'b0; v = rnd(); dsp_out = v; sb.push_back({v, 4'd7}); res_ready = 1'b1;
    tick();
    res_ready = 1'b0; dsp_out = rnd();
    chk("pp_level", 128'(level), 128'(4));
    chk("pp_noovf", 128'(overflow), 128'(0));
    res_ready = 1'b1;
    repeat (4) tick();
    chk("pp_drained", 128'(level), 128'(0));
    // illegal mode, then reset in the middle of a four pass operation
    start = 1'b1; mode = 2'd3; tag = 4'd6;
    tick();
    start = 1'b0;
    chk("ill_err", 128'(err), 128'(1));
    chk("ill_busy", 128'(busy), 128'(0));
    chk("ill_level", 128'(level), 128'(0));
    start = 1'b1; mode = 2'd2; tag = 4'd8;
    tick();
    start = 1'b0;
    tick();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      dsp_out = rnd();
      tick();
    end
    chk("rst_nocap", 128'(level), 128'(0));
    chk("rst_nobusy", 128'(busy), 128'(0));
    chk("rst_noerr", 128'(err), 128'(0));
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
